// File: rtl/pipeline_ex_stage_if.sv
// ID -> EX control/operand bundle and the EX/MEM result bundle.
// The ID side drives decoded fields; the EX side returns registered results.
interface pipeline_ex_stage_if;
    logic [63:0] pc_ID;
    logic [63:0] reg_data1_ID;
    logic [63:0] reg_data2_ID;
    logic [63:0] imm_ID;
    logic [4:0]  rd_ID;
    logic        rf_wr_en;
    logic        do_jump;
    logic        alu_a_sel;
    logic        alu_b_sel;
    logic [3:0]  alu_ctrl;
    logic [2:0]  BrType;
    logic [1:0]  rf_wr_sel;
    logic [2:0]  dm_rd_ctrl;
    logic [1:0]  dm_wr_ctrl;
    logic        stall;

    logic [63:0] alu_result_EX;
    logic [63:0] store_data_EX;
    logic [63:0] pc4_EX;
    logic [4:0]  rd_EX;
    logic        rf_wr_en_EX;
    logic [1:0]  rf_wr_sel_EX;
    logic [2:0]  dm_rd_ctrl_EX;
    logic [1:0]  dm_wr_ctrl_EX;
    logic        redirect_EX;
    logic [63:0] redirect_pc_EX;

    modport master (
        output pc_ID, reg_data1_ID, reg_data2_ID, imm_ID, rd_ID,
        output rf_wr_en, do_jump, alu_a_sel, alu_b_sel, alu_ctrl,
        output BrType, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl, stall,
        input  alu_result_EX, store_data_EX, pc4_EX, rd_EX,
        input  rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX,
        input  redirect_EX, redirect_pc_EX
    );

    modport slave (
        input  pc_ID, reg_data1_ID, reg_data2_ID, imm_ID, rd_ID,
        input  rf_wr_en, do_jump, alu_a_sel, alu_b_sel, alu_ctrl,
        input  BrType, rf_wr_sel, dm_rd_ctrl, dm_wr_ctrl, stall,
        output alu_result_EX, store_data_EX, pc4_EX, rd_EX,
        output rf_wr_en_EX, rf_wr_sel_EX, dm_rd_ctrl_EX, dm_wr_ctrl_EX,
        output redirect_EX, redirect_pc_EX
    );
endinterface

// File: rtl/pipeline_ex_stage.sv
// Execute stage: ALU, branch resolution, redirect and post-redirect squash.
// All outputs are registered; stall freezes every flop in the stage.
module pipeline_ex_stage #(
    parameter int unsigned KILL_SLOTS = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_ex_stage_if.slave    bus
);

    localparam logic [1:0] KILL_INIT = KILL_SLOTS[1:0];

    typedef enum logic {RUN, KILL} state_t;

    state_t      state_q, state_d;
    logic [1:0]  kill_q, kill_d;

    logic [63:0] alu_q, alu_d;
    logic [63:0] store_q, store_d;
    logic [63:0] pc4_q, pc4_d;
    logic [4:0]  rd_q, rd_d;
    logic        we_q, we_d;
    logic [1:0]  wsel_q, wsel_d;
    logic [2:0]  rdc_q, rdc_d;
    logic [1:0]  wrc_q, wrc_d;
    logic        redir_q, redir_d;
    logic [63:0] tgt_q, tgt_d;

    logic [63:0] op_a, op_b, alu;
    logic [5:0]  shamt;
    logic        br_true, taken, squash;
    logic [63:0] rs1, rs2;

    // Operand select and ALU
    always_comb begin
        op_a  = bus.alu_a_sel ? bus.pc_ID : bus.reg_data1_ID;
        op_b  = bus.alu_b_sel ? bus.imm_ID : bus.reg_data2_ID;
        shamt = op_b[5:0];
        case (bus.alu_ctrl)
            4'd1:    alu = op_a - op_b;
            4'd2:    alu = op_a << shamt;
            4'd3:    alu = {63'd0, $signed(op_a) < $signed(op_b)};
            4'd4:    alu = {63'd0, op_a < op_b};
            4'd5:    alu = op_a ^ op_b;
            4'd6:    alu = op_a >> shamt;
            4'd7:    alu = $unsigned($signed(op_a) >>> shamt);
            4'd8:    alu = op_a | op_b;
            4'd9:    alu = op_a & op_b;
            4'd10:   alu = op_b;
            default: alu = op_a + op_b;
        endcase
    end

    // Branch condition on the raw register operands
    always_comb begin
        rs1 = bus.reg_data1_ID;
        rs2 = bus.reg_data2_ID;
        case (bus.BrType)
            3'd1:    br_true = (rs1 == rs2);
            3'd2:    br_true = (rs1 != rs2);
            3'd3:    br_true = ($signed(rs1) < $signed(rs2));
            3'd4:    br_true = ($signed(rs1) >= $signed(rs2));
            3'd5:    br_true = (rs1 < rs2);
            3'd6:    br_true = (rs1 >= rs2);
            default: br_true = 1'b0;
        endcase
        taken = bus.do_jump | br_true;
    end

    // Next-state: capture on non-stalled edges, squash while in KILL
    always_comb begin
        squash  = (state_q == KILL);
        kill_d  = kill_q;
        alu_d   = alu_q;
        store_d = store_q;
        pc4_d   = pc4_q;
        rd_d    = rd_q;
        we_d    = we_q;
        wsel_d  = wsel_q;
        rdc_d   = rdc_q;
        wrc_d   = wrc_q;
        redir_d = redir_q;
        tgt_d   = tgt_q;
        if (!bus.stall) begin
            alu_d   = alu;
            store_d = bus.reg_data2_ID;
            pc4_d   = bus.pc_ID + 64'd4;
            rd_d    = bus.rd_ID;
            wsel_d  = bus.rf_wr_sel;
            tgt_d   = bus.do_jump ? {alu[63:1], 1'b0}
                                  : bus.pc_ID + bus.imm_ID;
            we_d    = bus.rf_wr_en & ~squash;
            rdc_d   = squash ? 3'd0 : bus.dm_rd_ctrl;
            wrc_d   = squash ? 2'd0 : bus.dm_wr_ctrl;
            redir_d = taken & ~squash;
            if (squash)     kill_d = kill_q - 2'd1;
            else if (taken) kill_d = KILL_INIT;
            else            kill_d = 2'd0;
        end
        state_d = (kill_d != 2'd0) ? KILL : RUN;
    end

    // Stage registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            kill_q  <= 2'd0;
            alu_q   <= '0;
            store_q <= '0;
            pc4_q   <= '0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            wsel_q  <= '0;
            rdc_q   <= '0;
            wrc_q   <= '0;
            redir_q <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            pc4_q   <= pc4_d;
            rd_q    <= rd_d;
            we_q    <= we_d;
            wsel_q  <= wsel_d;
            rdc_q   <= rdc_d;
            wrc_q   <= wrc_d;
            redir_q <= redir_d;
            tgt_q   <= tgt_d;
        end
    end

    assign bus.alu_result_EX  = alu_q;
    assign bus.store_data_EX  = store_q;
    assign bus.pc4_EX         = pc4_q;
    assign bus.rd_EX          = rd_q;
    assign bus.rf_wr_en_EX    = we_q;
    assign bus.rf_wr_sel_EX   = wsel_q;
    assign bus.dm_rd_ctrl_EX  = rdc_q;
    assign bus.dm_wr_ctrl_EX  = wrc_q;
    assign bus.redirect_EX    = redir_q;
    assign bus.redirect_pc_EX = tgt_q;

endmodule

// File: tb/tb_pipeline_ex_stage.sv
// Scoreboard bench for pipeline_ex_stage: directed vectors with
// hand-computed results, checked by an independent monitor.
module tb_pipeline_ex_stage;

    typedef struct packed {
        logic        red;
        logic [63:0] tgt;
        logic [63:0] alu;
        logic [63:0] st;
        logic [63:0] pc4;
        logic [4:0]  rd;
        logic        we;
        logic [1:0]  wsel;
        logic [2:0]  rdc;
        logic [1:0]  wrc;
    } exp_t;

    localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   n_issued;
    exp_t sb[$];
    exp_t last_exp;

    pipeline_ex_stage_if bus ();

    pipeline_ex_stage #(.KILL_SLOTS(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one registered result per clock edge while work is pending
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("redirect", 64'(bus.redirect_EX), 64'(e.red));
                chk("redirect_pc", bus.redirect_pc_EX, e.tgt);
                chk("alu_result", bus.alu_result_EX, e.alu);
                chk("store_data", bus.store_data_EX, e.st);
                chk("pc4", bus.pc4_EX, e.pc4);
                chk("rd", 64'(bus.rd_EX), 64'(e.rd));
                chk("rf_wr_en", 64'(bus.rf_wr_en_EX), 64'(e.we));
                chk("rf_wr_sel", 64'(bus.rf_wr_sel_EX), 64'(e.wsel));
                chk("dm_rd_ctrl", 64'(bus.dm_rd_ctrl_EX), 64'(e.rdc));
                chk("dm_wr_ctrl", 64'(bus.dm_wr_ctrl_EX), 64'(e.wrc));
            end
        end
    end

    task automatic op(
        input logic [63:0] pc, input logic [63:0] a,
        input logic [63:0] b, input logic [63:0] imm,
        input logic asel, input logic bsel, input logic [3:0] ctrl,
        input logic [2:0] br, input logic jmp, input logic we,
        input logic [2:0] rdc, input logic [1:0] wrc,
        input logic [63:0] e_alu, input logic [63:0] e_tgt,
        input logic e_red, input logic e_sq);
        exp_t e;
        @(negedge clk);
        n_issued++;
        bus.stall        = 1'b0;
        bus.pc_ID        = pc;
        bus.reg_data1_ID = a;
        bus.reg_data2_ID = b;
        bus.imm_ID       = imm;
        bus.alu_a_sel    = asel;
        bus.alu_b_sel    = bsel;
        bus.alu_ctrl     = ctrl;
        bus.BrType       = br;
        bus.do_jump      = jmp;
        bus.rf_wr_en     = we;
        bus.dm_rd_ctrl   = rdc;
        bus.dm_wr_ctrl   = wrc;
        bus.rd_ID        = 5'(n_issued);
        bus.rf_wr_sel    = jmp ? 2'd2 : 2'd0;
        e.red  = e_red;
        e.tgt  = e_tgt;
        e.alu  = e_alu;
        e.st   = b;
        e.pc4  = pc + 64'd4;
        e.rd   = 5'(n_issued);
        e.we   = e_sq ? 1'b0 : we;
        e.wsel = jmp ? 2'd2 : 2'd0;
        e.rdc  = e_sq ? 3'd0 : rdc;
        e.wrc  = e_sq ? 2'd0 : wrc;
        last_exp = e;
        sb.push_back(e);
    endtask

    task automatic stall_for(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.stall        = 1'b1;
            bus.pc_ID        = 64'hDEAD_0000 + 64'(i);
            bus.reg_data1_ID = 64'h1234;
            bus.reg_data2_ID = 64'h1234;
            bus.BrType       = 3'd1;
            bus.rf_wr_en     = 1'b1;
            bus.dm_wr_ctrl   = 2'd1;
            bus.rd_ID        = 5'd31;
            sb.push_back(last_exp);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        n_issued = 0;
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.pc_ID = '0;
        bus.reg_data1_ID = '0;
        bus.reg_data2_ID = '0;
        bus.imm_ID = '0;
        bus.rd_ID = '0;
        bus.rf_wr_en = 1'b0;
        bus.do_jump = 1'b0;
        bus.alu_a_sel = 1'b0;
        bus.alu_b_sel = 1'b0;
        bus.alu_ctrl = '0;
        bus.BrType = '0;
        bus.rf_wr_sel = '0;
        bus.dm_rd_ctrl = '0;
        bus.dm_wr_ctrl = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_alu", bus.alu_result_EX, 64'd0);
        chk("rst_redirect", 64'(bus.redirect_EX), 64'd0);
        chk("rst_pc4", bus.pc4_EX, 64'd0);
        chk("rst_wr_en", 64'(bus.rf_wr_en_EX), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // ALU coverage
        op(0, 5, 0, 7, 0, 1, 0, 0, 0, 1, 0, 0, 64'd12, 64'd7, 0, 0);
        op(0, 64'h8000_0000_0000_0000, 4, 0, 0, 0, 7, 0, 0, 1, 0, 0,
           64'hF800_0000_0000_0000, 64'd0, 0, 0);
        op(0, M1, 1, 0, 0, 0, 4, 0, 0, 1, 0, 0, 64'd0, 64'd0, 0, 0);
        op(0, M1, 1, 0, 0, 0, 3, 0, 0, 1, 0, 0, 64'd1, 64'd0, 0, 0);
        op(0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 0, 0, M1, 64'd0, 0, 0);
        op(0, 1, 64'h7F, 0, 0, 0, 2, 0, 0, 1, 0, 0,
           64'h8000_0000_0000_0000, 64'd0, 0, 0);
        op(0, 9, 0, 64'hABC, 0, 1, 10, 0, 0, 1, 0, 0,
           64'hABC, 64'hABC, 0, 0);
        op(0, 2, 3, 0, 0, 0, 13, 0, 0, 1, 0, 0, 64'd5, 64'd0, 0, 0);
        op(64'h200, 1, M1, 64'h40, 0, 0, 0, 6, 0, 1, 0, 0,
           64'd0, 64'h240, 0, 0);

        // BEQ taken, two squashed (second is a taken BNE), third passes
        op(64'h100, 3, 3, 64'h20, 0, 0, 1, 1, 0, 0, 0, 0,
           64'd0, 64'h120, 1, 0);
        op(64'h104, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd3, 64'h104, 0, 1);
        op(64'h108, 1, 2, 64'h80, 0, 0, 0, 2, 0, 1, 0, 2,
           64'd3, 64'h188, 0, 1);
        op(64'h10C, 1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd3, 64'h10C, 0, 0);

        // JALR: target clears bit 0
        op(64'h300, 64'h2001, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0,
           64'h2001, 64'h2000, 1, 0);
        op(64'h304, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,
           64'd0, 64'h304, 0, 1);
        op(64'h308, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,
           64'd0, 64'h308, 0, 1);
        op(64'h30C, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,
           64'd0, 64'h30C, 0, 0);

        // Stall while redirect is up; kill window survives the stall
        op(64'h500, 7, 7, 64'h10, 0, 0, 0, 1, 0, 0, 0, 0,
           64'd14, 64'h510, 1, 0);
        stall_for(3);
        op(64'h504, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd2, 64'h504, 0, 1);
        op(64'h508, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd2, 64'h508, 0, 1);
        op(64'h50C, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd2, 64'h50C, 0, 0);

        // Reset in the middle of a kill window
        op(64'h400, M1, 1, 64'h10, 0, 0, 3, 3, 0, 0, 0, 0,
           64'd1, 64'h410, 1, 0);
        op(64'h404, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 2,
           64'd2, 64'h404, 0, 1);
        drain();
        #2;
        reset = 1'b0;
        #1;
        chk("async_alu", bus.alu_result_EX, 64'd0);
        chk("async_redirect_pc", bus.redirect_pc_EX, 64'd0);
        chk("async_pc4", bus.pc4_EX, 64'd0);
        chk("async_store", bus.store_data_EX, 64'd0);
        chk("async_rd", 64'(bus.rd_EX), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        op(64'h600, 64'h1000, 64'h55, 8, 0, 1, 0, 0, 0, 0, 0, 3,
           64'h1008, 64'h608, 0, 0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_ex_stage.md
PIPELINE_EX_STAGE -- requirements
Module: pipeline_ex_stage

Interface
REQ-001 Parameter KILL_SLOTS, default 2, number of younger instructions squashed after a taken redirect (legal 1..3).
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port reset  input  1  asynchronous, active-low reset; one clock; no other reset exists.
REQ-004 Port pc_ID  input  64  PC of instruction in ID/EX.
REQ-005 Ports reg_data1_ID, reg_data2_ID, imm_ID  input  64 each  operands and immediate from ID.
REQ-006 Port rd_ID  input  5  destination register.
REQ-007 Ports rf_wr_en, do_jump, alu_a_sel, alu_b_sel  input  1 each  decoded controls.
REQ-008 Ports alu_ctrl 4, BrType 3, rf_wr_sel 2, dm_rd_ctrl 3, dm_wr_ctrl 2  input  decoded controls.
REQ-009 Port stall  input  1  high freezes all EX state and outputs.
REQ-010 Ports alu_result_EX, store_data_EX, pc4_EX  output  64 each  EX/MEM result, rs2 data, pc_ID+4.
REQ-011 Ports rd_EX 5, rf_wr_en_EX 1, rf_wr_sel_EX 2, dm_rd_ctrl_EX 3, dm_wr_ctrl_EX 2  output  forwarded controls.
REQ-012 Ports redirect_EX  output  1, redirect_pc_EX  output  64  taken branch/jump to fetch.

Function
REQ-013 Operand A = alu_a_sel ? pc_ID : reg_data1_ID; operand B = alu_b_sel ? imm_ID : reg_data2_ID.
REQ-014 alu_ctrl: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 pass B; 11-15 ADD.
REQ-015 Shifts use B[5:0]; all arithmetic 64-bit modulo 2^64; SLT/SLTU yield 0 or 1.
REQ-016 BrType: 0 none, 1 EQ, 2 NE, 3 LT, 4 GE (signed), 5 LTU, 6 GEU, 7 none; compares reg_data1_ID vs reg_data2_ID.
REQ-017 Taken = do_jump OR branch condition true; target = do_jump ? {alu_result[63:1],1'b0} : pc_ID+imm_ID.
REQ-018 do_jump has priority over BrType; jump writes pc_ID+4 via rf_wr_sel path (pc4_EX).
REQ-019 On each rising edge with stall=0, all outputs register the computed values (latency 1 cycle).
REQ-020 stall=1: every output and kill counter hold; redirect_EX stays at its value until a non-stalled edge.
REQ-021 redirect_EX asserted for exactly one non-stalled cycle per taken, non-squashed instruction.
REQ-022 Kill counter (2 bits) loads KILL_SLOTS on an edge registering a taken redirect; decrements on each later non-stalled edge until 0.
REQ-023 While kill counter nonzero, captured instruction is squashed: rf_wr_en_EX=0, dm_rd_ctrl_EX=0, dm_wr_ctrl_EX=0, redirect_EX=0; data outputs still update.
REQ-024 A squashed taken instruction does not reload the counter.
REQ-025 States: RUN (counter 0) and KILL (counter >0); RUN->KILL on taken capture, KILL->RUN when counter reaches 0.

Reset
REQ-026 reset low: all outputs 0, kill counter 0, state RUN, immediately and independent of clk.
REQ-027 reset asserted mid-KILL or mid-stall abandons squashing; first instruction after release is not squashed.

Verification
REQ-028 ADD: a=5, b=imm 7, alu_b_sel=1, alu_ctrl=0 -> next edge alu_result_EX=12, redirect_EX=0.
REQ-029 SRA: a=0x8000_0000_0000_0000, b=4, ctrl=7 -> 0xF800_0000_0000_0000; SLTU -1 vs 1 -> 0.
REQ-030 BEQ taken: pc=0x100, imm=0x20, rs1=rs2=3, BrType=1 -> redirect_EX=1, redirect_pc_EX=0x120 one cycle; next 2 instructions (rf_wr_en=1, dm_wr_ctrl=2) emerge with rf_wr_en_EX=0, dm_wr_ctrl_EX=0; third passes.
REQ-031 JALR: a=0x2001, imm=0, do_jump=1 -> redirect_pc_EX=0x2000, pc4_EX=pc_ID+4.
REQ-032 stall=1 for 3 cycles while redirect_EX=1 -> redirect_EX and outputs hold; counter still 2 on release.
REQ-033 reset pulsed low during KILL -> outputs 0 asynchronously; post-release store with dm_wr_ctrl=3 appears unsquashed.
